// File: rtl/router_sync_n.sv
// Router synchroniser: latches the header destination, steers FIFO write
// strobes, and raises a soft_reset pulse for any output FIFO left unread.
module router_sync_n #(
  parameter int NUM_CH  = 3,
  parameter int ADDR_W  = 2,
  parameter int TIMEOUT = 30,
  parameter int TMR_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              detect_add,
  input  logic [ADDR_W-1:0] din,
  input  logic              write_enb_reg,
  input  logic [NUM_CH-1:0] read_enb,
  input  logic [NUM_CH-1:0] empty,
  input  logic [NUM_CH-1:0] full,
  output logic [NUM_CH-1:0] vld_out,
  output logic [NUM_CH-1:0] write_enb,
  output logic              fifo_full,
  output logic              addr_valid,
  output logic [NUM_CH-1:0] soft_reset,
  output logic [NUM_CH-1:0] sr_status,
  input  logic [NUM_CH-1:0] sr_clr
);

  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [ADDR_W:0]   CH_LIMIT = (ADDR_W + 1)'(NUM_CH);

  logic [ADDR_W-1:0] int_add;
  logic [TMR_W-1:0]  timer [NUM_CH];
  logic [NUM_CH-1:0] fire;

  // Address capture; the extra compare bit lets NUM_CH equal 2**ADDR_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      int_add    <= '0;
      addr_valid <= 1'b0;
    end else if (detect_add) begin
      int_add    <= din;
      addr_valid <= ({1'b0, din} < CH_LIMIT);
    end
  end

  // Out-of-range addresses never write and never stall the FSM.
  always_comb begin
    write_enb = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (addr_valid && (int_add == ADDR_W'(i))) begin
        write_enb[i] = write_enb_reg;
        fifo_full    = full[i];
      end
    end
  end

  assign vld_out = ~empty;

  always_comb begin
    fire = '0;
    for (int i = 0; i < NUM_CH; i++)
      fire[i] = vld_out[i] && !read_enb[i] && (timer[i] == TMR_LAST);
  end

  // Per-channel timeout window; any read or an empty FIFO restarts it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (reset) begin
        timer[i]      <= '0;
        soft_reset[i] <= 1'b0;
        sr_status[i]  <= 1'b0;
      end else begin
        if (!vld_out[i] || read_enb[i] || fire[i])
          timer[i] <= '0;
        else
          timer[i] <= timer[i] + TMR_W'(1);
        soft_reset[i] <= fire[i];
        if (fire[i])
          sr_status[i] <= 1'b1;
        else if (sr_clr[i])
          sr_status[i] <= 1'b0;
      end
    end
  end

endmodule
